// File: rtl/alu_exec_stage.sv
// alu_exec_stage: issue/execute/write-back stage feeding a combinational alu, with forwarding
// Ports: clk/rst (async active-high); in_* decoded op over valid/ready; hold stalls the stage;
// alu_* registered ALU inputs and alu_y/z/n/c/v results; flags {Z,N,C,V}; wb_* commit pulse;
// dbg_addr/dbg_data asynchronous register-file read.
module alu_exec_stage #(
    parameter int NREG = 8,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   in_op,
    input  logic [2:0]   in_rd,
    input  logic [2:0]   in_rs1,
    input  logic [2:0]   in_rs2,
    input  logic [W-1:0] in_imm,
    input  logic         in_imm_sel,
    input  logic         in_wb_en,
    input  logic         in_flag_we,
    input  logic         in_use_cin,
    input  logic         hold,
    output logic [W-1:0] alu_A,
    output logic [W-1:0] alu_B,
    output logic         alu_Ext_cin,
    output logic [4:0]   alu_ALUop,
    input  logic [W-1:0] alu_y,
    input  logic         alu_z,
    input  logic         alu_n,
    input  logic         alu_c,
    input  logic         alu_v,
    output logic [3:0]   flags,
    output logic         wb_valid,
    output logic [2:0]   wb_rd,
    output logic [W-1:0] wb_data,
    input  logic [2:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);
    logic [W-1:0] rf [NREG];
    logic         ex_valid;
    logic [2:0]   ex_rd;
    logic         ex_wb_en;
    logic         ex_flag_we;
    logic         fwd_ok;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;

    assign in_ready = !hold;
    assign dbg_data = dbg_addr == 3'd0 ? '0 : rf[dbg_addr];
    // The op still in EX writes alu_y at the same edge we sample, so it must win over the regfile.
    assign fwd_ok = ex_valid && ex_wb_en && ex_rd != 3'd0;

    always_comb begin
        op_a   = in_rs1 == 3'd0 ? '0 : (fwd_ok && ex_rd == in_rs1) ? alu_y : rf[in_rs1];
        op_b   = in_imm_sel ? in_imm : in_rs2 == 3'd0 ? '0 : (fwd_ok && ex_rd == in_rs2) ? alu_y : rf[in_rs2];
        op_cin = in_use_cin && ((ex_valid && ex_flag_we) ? alu_c : flags[1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_rd       <= '0;
            ex_wb_en    <= 1'b0;
            ex_flag_we  <= 1'b0;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_Ext_cin <= 1'b0;
            alu_ALUop   <= '0;
            flags       <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (hold) begin
            wb_valid <= 1'b0;
        end else begin
            ex_valid <= in_valid;
            if (in_valid) begin
                alu_A       <= op_a;
                alu_B       <= op_b;
                alu_Ext_cin <= op_cin;
                alu_ALUop   <= in_op;
                ex_rd       <= in_rd;
                ex_wb_en    <= in_wb_en;
                ex_flag_we  <= in_flag_we;
            end
            wb_valid <= ex_valid;
            if (ex_valid) begin
                wb_rd   <= ex_rd;
                wb_data <= alu_y;
                if (ex_wb_en && ex_rd != 3'd0) rf[ex_rd] <= alu_y;
                if (ex_flag_we) flags <= {alu_z, alu_n, alu_c, alu_v};
            end
        end
    end
endmodule
